dmem_access_unit: RTL and testbench

Data-memory access unit between the EX/MEM pipeline register and the backing data memory.
- Converts a load/store request into a valid/ready memory transaction with byte enables.
- Stalls the pipeline until the response returns.
- Presents lane-aligned load data on `dmemData`, where the MEM stage performs LB/LH/LW sign-extension.
- Detects misaligned or unsupported accesses and bounds memory latency with a timeout.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_access_unit.sv | 163 ++++++++++++++++
 tb/tb_dmem_access_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and constants for the data-memory access unit.
//  Revision : 1.0
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DONE      = 2'd3
    } dmem_state_t;

    localparam logic [2:0] DMEM_BYTE = 3'b000;
    localparam logic [2:0] DMEM_HALF = 3'b001;
    localparam logic [2:0] DMEM_WORD = 3'b010;

    localparam int DMEM_TIMEOUT_DEFAULT = 255;

    // Wide enough to hold the limit value itself.
    function automatic int dmem_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lane_align
//  Purpose  : Legality check, byte enables, store replication, load shift.
//  Revision : 1.0
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  rd_offset_i,
    input  logic [31:0] rdata_i,
    output logic        legal_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        legal_o = 1'b0;
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case (funct3_i)
            DMEM_BYTE: begin
                legal_o = 1'b1;
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            DMEM_HALF: begin
                legal_o = ~addr_lo_i[0];
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            DMEM_WORD: begin
                legal_o = (addr_lo_i == 2'b00);
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

    // Addressed lane lands at bit 0; vacated upper bits fill with zero.
    assign rdata_o = rdata_i >> {rd_offset_i, 3'b000};

endmodule : dmem_lane_align
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_unit
//  Purpose  : Turns EX/MEM load/store requests into valid/ready memory
//             transactions, stalling the pipeline until completion.
//  Revision : 1.0
// ============================================================================
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] dmemData,
    output logic        access_fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [3:0]  mem_req_be,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int               CNT_W     = dmem_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [1:0]       off_q;
    logic [31:0]      data_q, data_d;
    logic             fault_q, fault_d;
    logic             cap_en;

    logic             w_legal;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_rep;
    logic [31:0]      w_rdata_shift;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;

    dmem_lane_align u_lane_align (
        .funct3_i    (req_funct3),
        .addr_lo_i   (req_addr[1:0]),
        .wdata_i     (req_wdata),
        .rd_offset_i (off_q),
        .rdata_i     (mem_resp_data),
        .legal_o     (w_legal),
        .be_o        (w_be),
        .wdata_o     (w_wdata_rep),
        .rdata_o     (w_rdata_shift)
    );

    // The current cycle is the last one allowed in ISSUE+WAIT_RESP.
    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_timeout = (w_cnt_inc == CNT_LIMIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fault_d = 1'b0;
        cap_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_legal) begin
                        state_d = ST_ISSUE;
                        cap_en  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                        data_d  = 32'h0;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = w_cnt_inc;
                if (w_timeout) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    data_d  = 32'h0;
                end else if (mem_req_ready) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                cnt_d = w_cnt_inc;
                // A response arriving on the final allowed cycle beats the timeout.
                if (mem_resp_valid) begin
                    state_d = ST_DONE;
                    data_d  = we_q ? 32'h0 : w_rdata_shift;
                end else if (w_timeout) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    data_d  = 32'h0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            off_q   <= 2'b00;
        end else if (cap_en) begin
            addr_q  <= {req_addr[31:2], 2'b00};
            we_q    <= req_is_store;
            be_q    <= w_be;
            wdata_q <= w_wdata_rep;
            off_q   <= req_addr[1:0];
        end
    end

    assign stall         = ((state_q == ST_IDLE) && req_valid)
                         || (state_q == ST_ISSUE)
                         || (state_q == ST_WAIT_RESP);
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_be    = be_q;
    assign mem_req_wdata = wdata_q;
    assign dmemData      = data_q;
    assign access_fault  = fault_q;

endmodule : dmem_access_unit
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_access_unit
//  Purpose  : Directed and randomized self-checking bench for dmem_access_unit.
//  Revision : 1.0
// ============================================================================
module tb_dmem_access_unit;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, access_fault, mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] dmemData, mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] prev_data = 32'h0;

    always #5 clk = ~clk;

    dmem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clock          (clk),
        .reset          (rst),
        .req_valid      (req_valid),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .dmemData       (dmemData),
        .access_fault   (access_fault),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_be     (mem_req_be),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
        chk({tag, "_mvalid"}, {31'h0, mem_req_valid}, 32'h0);
        chk({tag, "_we"}, {31'h0, mem_req_we}, 32'h0);
        chk({tag, "_fault"}, {31'h0, access_fault}, 32'h0);
        chk({tag, "_addr"}, mem_req_addr, 32'h0);
        chk({tag, "_be"}, {28'h0, mem_req_be}, 32'h0);
        chk({tag, "_wdata"}, mem_req_wdata, 32'h0);
        chk({tag, "_data"}, dmemData, 32'h0);
    endtask

    // One access. rd = ISSUE cycles before ready is raised; rs = WAIT cycles
    // before the response. Expected outcome comes from the cycle budget T.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int rd, input int rs,
                             input logic [31:0] word);
        int          size, off, n_issue, n_wait, done;
        bit          legal, tmo;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_data;
        off   = int'(addr[1:0]);
        size  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        legal = (f3 <= 3'd2) && (off % size == 0);
        for (int b = 0; b < 4; b++) begin
            exp_be[b]         = (b >= off) && (b < off + size);
            exp_wd[8*b +: 8]  = wd[8*(b % size) +: 8];
        end
        n_issue = 0;
        n_wait  = 0;
        tmo     = 1'b0;
        if (!legal) begin
            done = 1;
        end else begin
            if (rd + 1 >= T) begin
                n_issue = T;
                tmo     = 1'b1;
            end else begin
                n_issue = rd + 1;
                if (rs + 1 <= T - n_issue) n_wait = rs + 1;
                else begin
                    n_wait = T - n_issue;
                    tmo    = 1'b1;
                end
            end
            done = 1 + n_issue + n_wait;
        end
        exp_data = (!legal || tmo || st) ? 32'h0 : (word >> (8 * off));

        for (int c = 0; c <= done; c++) begin
            @(negedge clk);
            req_valid      = (c < done);
            req_is_store   = st;
            req_funct3     = f3;
            req_addr       = addr;
            req_wdata      = wd;
            mem_req_ready  = legal && (c == rd + 1);
            if (legal && c == 1 + n_issue + rs) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = word;
            end else begin
                // Spurious responses while still in ISSUE must be ignored.
                mem_resp_valid = legal && (c >= 1) && (c <= n_issue) && ($urandom_range(0, 1) == 1);
                mem_resp_data  = $urandom;
            end
            #1;
            if (c == 0) begin
                chk("idle_fault", {31'h0, access_fault}, 32'h0);
                chk("data_hold", dmemData, prev_data);
            end
            if (c < done) begin
                chk("stall_hi", {31'h0, stall}, 32'h1);
                chk("mreq_valid", {31'h0, mem_req_valid},
                    {31'h0, (legal && c >= 1 && c <= n_issue)});
                if (legal && c >= 1 && c <= n_issue) begin
                    chk("mreq_addr", mem_req_addr, {addr[31:2], 2'b00});
                    chk("mreq_be", {28'h0, mem_req_be}, {28'h0, exp_be});
                    chk("mreq_we", {31'h0, mem_req_we}, {31'h0, st});
                    if (st) chk("mreq_wdata", mem_req_wdata, exp_wd);
                end
            end else begin
                chk("done_stall", {31'h0, stall}, 32'h0);
                chk("done_mvalid", {31'h0, mem_req_valid}, 32'h0);
                chk("done_fault", {31'h0, access_fault}, {31'h0, (!legal || tmo)});
                chk("done_data", dmemData, exp_data);
            end
        end
        prev_data = exp_data;
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_is_store   = 1'b0;
        req_funct3     = 3'd0;
        req_addr       = 32'h0;
        req_wdata      = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_access(1'b0, 3'd2, 32'h0000_0100, 32'h0,         0, 0, 32'hDEAD_BEEF);
        do_access(1'b0, 3'd0, 32'h0000_0103, 32'h0,         0, 0, 32'h8011_2233);
        do_access(1'b1, 3'd1, 32'h0000_0102, 32'h0000_ABCD, 0, 0, 32'h0);
        do_access(1'b0, 3'd2, 32'h0000_0101, 32'h0,         0, 0, 32'h1234_5678);
        do_access(1'b0, 3'd1, 32'h0000_0203, 32'h0,         0, 0, 32'h1234_5678);
        do_access(1'b0, 3'd3, 32'h0000_0200, 32'h0,         0, 0, 32'h1234_5678);
        do_access(1'b0, 3'd2, 32'h0000_0300, 32'h0,         4, 5, 32'hCAFE_F00D);
        do_access(1'b0, 3'd1, 32'h0000_0302, 32'h0,         0, 14, 32'h5566_7788);
        do_access(1'b0, 3'd2, 32'h0000_0304, 32'h0,         0, 15, 32'h5566_7788);
        do_access(1'b1, 3'd0, 32'h0000_0401, 32'h0000_00A5, 40, 0, 32'h0);
        do_access(1'b0, 3'd2, 32'h0000_0500, 32'h0,         T - 2, 0, 32'h0BAD_F00D);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            do_access(1'($urandom_range(0, 1)), f3, $urandom, $urandom,
                      $urandom_range(0, 5), $urandom_range(0, 6), $urandom);
        end

        // Reset while waiting for a response
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h0000_0600; req_wdata = 32'h1111_2222;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("wait_stall", {31'h0, stall}, 32'h1);
        chk("wait_mvalid", {31'h0, mem_req_valid}, 32'h0);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst       = 1'b0;
        prev_data = 32'h0;
        do_access(1'b0, 3'd0, 32'h0000_0702, 32'h0, 1, 1, 32'hA1B2_C3D4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dmem_access_unit
`default_nettype wire
